// File: rtl/sensor_scheduler_if.sv
// sensor_scheduler_if: bundle between the sensor buffers, the scheduler and the UART TX.
interface sensor_scheduler_if #(
    parameter int N_SENSORS = 8,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 3
);
    logic [N_SENSORS-1:0]        sensor_ready;
    logic [N_SENSORS*DATA_W-1:0] sensor_bus;
    logic                        shipping_done;
    logic [N_SENSORS-1:0]        data_used;
    logic [DATA_W-1:0]           data_to_send;
    logic                        tx_start;
    logic                        tx_busy;
    logic [IDX_W-1:0]            sensor;
    logic                        timeout_err;
    modport slave (
        input  sensor_ready, sensor_bus, shipping_done,
        output data_used, data_to_send, tx_start, tx_busy, sensor, timeout_err
    );
    modport master (
        output sensor_ready, sensor_bus, shipping_done,
        input  data_used, data_to_send, tx_start, tx_busy, sensor, timeout_err
    );
endinterface

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: arbitrates ready sensors, hands one word at a time to the UART TX
// and waits for shipping_done (with optional timeout) before the next grant.
module sensor_scheduler #(
    parameter int N_SENSORS   = 8,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 3,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    sensor_scheduler_if.slave  bus
);
    localparam int CNT_W = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_q, rr_d, sensor_q, sensor_d, win;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [N_SENSORS-1:0] used_q, used_d;
    logic                 start_q, start_d, busy_q, busy_d, err_q, err_d;
    int                   base;
    // Descending scan so the candidate closest to the search base is written last and wins.
    always_comb begin
        base = ARB_MODE != 0 ? 0 : (int'(rr_q) + 1) % N_SENSORS;
        win  = '0;
        for (int k = N_SENSORS - 1; k >= 0; k--)
            if (|(bus.sensor_ready & (N_SENSORS'(1) << ((base + k) % N_SENSORS))))
                win = IDX_W'((base + k) % N_SENSORS);
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        rr_d     = rr_q;
        sensor_d = sensor_q;
        data_d   = data_q;
        used_d   = '0;
        start_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (|bus.sensor_ready) begin
                state_d  = SEND;
                sensor_d = win;
                rr_d     = win;
                data_d   = DATA_W'(bus.sensor_bus >> (int'(win) * DATA_W));
                used_d   = N_SENSORS'(1) << win;
            end
            SEND: begin
                state_d = WAIT;
                start_d = 1'b1;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.shipping_done) state_d = IDLE;
                else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_q     <= IDX_W'(N_SENSORS - 1);
            sensor_q <= '0;
            data_q   <= '0;
            used_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            sensor_q <= sensor_d;
            data_q   <= data_d;
            used_q   <= used_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end
    assign bus.data_used    = used_q;
    assign bus.data_to_send = data_q;
    assign bus.tx_start     = start_q;
    assign bus.tx_busy      = busy_q;
    assign bus.sensor       = sensor_q;
    assign bus.timeout_err  = err_q;
endmodule
